// File: rtl/ssi_master.sv
// SSI absolute-encoder master: divided SSI clock, MSB-first frame capture, optional Gray decode.
// Latency: pos_valid 2*W*CLK_DIV cycles after the CHECK->CLOCK edge (one extra bit period with parity).
// Backpressure: none; start is honoured only in IDLE, and requests while busy are dropped.
//
// Optional build macro: SSI_PARITY_EN adds a trailing even-parity bit period and drives parity_err.
//
// Ports:
//   enc_clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   start, cont            single-frame request (IDLE only) / back-to-back auto-repeat
//   enc_width, gray_en     frame width and Gray decode select, latched when clocking begins
//   enc_data               synchronised SSI data from the encoder line receiver
//   oclk                   registered SSI clock, idles high
//   enc_pos, pos_valid     last good position (right-aligned) and its one-cycle update strobe
//   busy                   high in every state except IDLE
//   err_line               sticky line fault, cleared by the next good frame
//   parity_err             one-cycle parity failure pulse (tied low without SSI_PARITY_EN)
module ssi_master #(
  parameter int MAX_W    = 40,
  parameter int CLK_DIV  = 1,
  parameter int MONO_CYC = 42,
  parameter int TMO_CYC  = 255
) (
  input  logic             enc_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [5:0]       enc_width,
  input  logic             gray_en,
  input  logic             enc_data,
  output logic             oclk,
  output logic [MAX_W-1:0] enc_pos,
  output logic             pos_valid,
  output logic             busy,
  output logic             err_line,
  output logic             parity_err
);

  localparam int BW = $clog2(MAX_W + 2);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MW = $clog2(MONO_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);
`ifdef SSI_PARITY_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif

  typedef enum logic [1:0] {IDLE, CHECK, CLOCK, MONO} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    width_q;
  logic             gray_q;
  logic [MAX_W-1:0] sr;
  logic [MW-1:0]    mono_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic             half_done, last_bit, tmo_hit, mono_done, bit_d;
`ifdef SSI_PARITY_EN
  logic             par_acc;
`endif

  assign half_done = (div_cnt == DW'(CLK_DIV - 1));
  // Total bit periods in a frame: data bits plus the optional parity period.
  assign last_bit  = (bit_cnt == width_q + BW'(XB));
  assign tmo_hit   = (tmo_cnt == TW'(TMO_CYC - 1));
  assign mono_done = (mono_cnt == MW'(MONO_CYC - 1));
  // sr is cleared at frame start, so sr[0] is the previous decoded bit (0 before the MSB).
  assign bit_d     = gray_q ? (enc_data ^ sr[0]) : enc_data;
  assign busy      = (state != IDLE);

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || cont) state_nxt = CHECK;
      CHECK:   if (enc_data) state_nxt = CLOCK;
               else if (tmo_hit) state_nxt = IDLE;
      CLOCK:   if (oclk && half_done && last_bit) state_nxt = MONO;
      MONO:    if (mono_done) state_nxt = cont ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      oclk      <= 1'b1;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      width_q   <= '0;
      gray_q    <= 1'b0;
      sr        <= '0;
      mono_cnt  <= '0;
      tmo_cnt   <= '0;
      enc_pos   <= '0;
      pos_valid <= 1'b0;
      err_line  <= 1'b0;
`ifdef SSI_PARITY_EN
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      pos_valid <= 1'b0;
      tmo_cnt   <= '0;
`ifdef SSI_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        CHECK: begin
          if (enc_data) begin
            // Encoder ready: latch frame configuration and start the first low phase.
            oclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            gray_q  <= gray_en;
            if (enc_width == 6'd0)            width_q <= BW'(1);
            else if (int'(enc_width) > MAX_W) width_q <= BW'(MAX_W);
            else                              width_q <= BW'(enc_width);
`ifdef SSI_PARITY_EN
            par_acc <= 1'b0;
`endif
          end else if (tmo_hit) begin
            err_line <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        CLOCK: begin
          if (!half_done) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            if (!oclk) begin
              // Rising edge of oclk: capture the bit presented during the low phase.
              oclk    <= 1'b1;
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt < width_q) sr <= {sr[MAX_W-2:0], bit_d};
`ifdef SSI_PARITY_EN
              par_acc <= par_acc ^ enc_data;
`endif
            end else if (last_bit) begin
              mono_cnt <= '0;
`ifdef SSI_PARITY_EN
              if (par_acc) begin
                parity_err <= 1'b1;
              end else begin
                enc_pos   <= sr;
                pos_valid <= 1'b1;
                err_line  <= 1'b0;
              end
`else
              enc_pos   <= sr;
              pos_valid <= 1'b1;
              err_line  <= 1'b0;
`endif
            end else begin
              oclk <= 1'b0;
            end
          end
        end
        MONO:    mono_cnt <= mono_cnt + MW'(1);
        default: ;
      endcase
    end
  end

`ifndef SSI_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
